// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: turns single read/write commands from a valid/ready port
// into classic Wishbone cycles on the WBs_* signal set and returns the read
// data, or a timeout error, on a buffered response port.
module wb_cmd_initiator #(
    parameter int ADR_W          = 17,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic             WB_CLK,
    input  logic             WB_RST_n,
    // command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [3:0]       cmd_be,
    input  logic [31:0]      cmd_wdat,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdat,
    output logic             rsp_err,
    // Wishbone initiator side
    output logic [ADR_W-1:0] WBs_ADR,
    output logic             WBs_CYC,
    output logic             WBs_STB,
    output logic             WBs_WE,
    output logic             WBs_RD,
    output logic [3:0]       WBs_BYTE_STB,
    output logic [31:0]      WBs_WR_DAT,
    input  logic [31:0]      WBs_RD_DAT,
    input  logic             WBs_ACK
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdat;
    } rsp_t;

    // A zero TIMEOUT_CYCLES leaves the cycle open until the client ACKs.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    rsp_t             rsp_q;
    logic             accept, ack_hit, timeout_hit;

    // State register; reset drops straight back to IDLE, losing any response.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state and handshake strobes; ACK beats a timeout on the same edge.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        accept      = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (WBs_ACK) begin
                    ack_hit   = 1'b1;
                    state_nxt = RESP;
                end else if (TO_EN && cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drivers: latch the command on accept, drop only the control strobes
    // when the cycle ends so address/data/byte lanes keep their last values.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            WBs_ADR      <= '0;
            WBs_BYTE_STB <= '0;
            WBs_WR_DAT   <= '0;
            WBs_WE       <= 1'b0;
            WBs_CYC      <= 1'b0;
            WBs_STB      <= 1'b0;
            WBs_RD       <= 1'b0;
        end else if (accept) begin
            WBs_ADR      <= cmd_adr;
            WBs_BYTE_STB <= cmd_be;
            WBs_WR_DAT   <= cmd_wdat;
            WBs_WE       <= cmd_we;
            WBs_CYC      <= 1'b1;
            WBs_STB      <= 1'b1;
            WBs_RD       <= ~cmd_we;
        end else if (ack_hit || timeout_hit) begin
            WBs_WE  <= 1'b0;
            WBs_CYC <= 1'b0;
            WBs_STB <= 1'b0;
            WBs_RD  <= 1'b0;
        end
    end

    // Timeout counter: counts edges spent in BUS without an ACK.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n)                    cnt <= '0;
        else if (accept)                  cnt <= '0;
        else if (state == BUS && TO_EN)   cnt <= cnt + 1'b1;
    end

    // Response capture; held untouched through RESP so stray ACKs are ignored.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            rsp_q <= '0;
        end else if (ack_hit) begin
            rsp_q.err  <= 1'b0;
            rsp_q.rdat <= WBs_RD ? WBs_RD_DAT : 32'h0;
        end else if (timeout_hit) begin
            rsp_q.err  <= 1'b1;
            rsp_q.rdat <= 32'h0;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_rdat  = rsp_q.rdat;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: the bench plays the Wishbone client,
// drives commands and compares against hand-computed values.
module tb_wb_cmd_initiator;
    localparam int ADR_W = 17;
    localparam logic [31:0] RD_BG = 32'h5555_AAAA;

    logic             WB_CLK = 1'b0;
    logic             WB_RST_n = 1'b0;
    logic             cmd_valid, cmd_ready, cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [3:0]       cmd_be;
    logic [31:0]      cmd_wdat;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_rdat;
    logic [ADR_W-1:0] WBs_ADR;
    logic             WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ACK;
    logic [3:0]       WBs_BYTE_STB;
    logic [31:0]      WBs_WR_DAT, WBs_RD_DAT;

    int n_chk = 0;
    int n_err = 0;
    int n_stb;
    logic ok;

    always #5 WB_CLK = ~WB_CLK;

    wb_cmd_initiator #(.ADR_W(ADR_W), .TIMEOUT_CYCLES(8), .CNT_W(9)) dut (
        .WB_CLK(WB_CLK), .WB_RST_n(WB_RST_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_be(cmd_be), .cmd_wdat(cmd_wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat),
        .rsp_err(rsp_err),
        .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE),
        .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT),
        .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge WB_CLK);
        #1;
    endtask

    // Issue one command and act as client: ACK in STB cycle waits+1 (waits<0: never).
    task automatic run_cmd(input logic we, input logic [ADR_W-1:0] adr, input logic [3:0] be,
                           input logic [31:0] wdat, input int waits, input logic [31:0] rd,
                           output int stb_n);
        logic bus_ok;
        cmd_we = we; cmd_adr = adr; cmd_be = be; cmd_wdat = wdat; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        stb_n = 0;
        bus_ok = 1'b1;
        for (int i = 0; i < 40 && WBs_STB; i++) begin
            stb_n++;
            bus_ok &= WBs_CYC && WBs_ADR == adr && WBs_BYTE_STB == be && WBs_WR_DAT == wdat
                      && WBs_WE == we && WBs_RD == !we;
            if (stb_n == waits + 1) begin
                WBs_ACK = 1'b1;
                WBs_RD_DAT = rd;
            end
            step();
            WBs_ACK = 1'b0;
            WBs_RD_DAT = RD_BG;
        end
        chk("bus_end", 32'(WBs_STB), 32'd0);
        chk("bus_hold", 32'(bus_ok), 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_be = '0; cmd_wdat = '0;
        rsp_ready = 1'b0; WBs_ACK = 1'b0; WBs_RD_DAT = RD_BG;

        // reset state
        #12;
        chk("rst_ctl", {28'd0, WBs_CYC, WBs_STB, WBs_RD, WBs_WE}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdat", rsp_rdat, 32'd0);
        chk("rst_adr", 32'(WBs_ADR), 32'd0);
        @(negedge WB_CLK) WB_RST_n = 1'b1;
        step();
        chk("idle_ready", 32'(cmd_ready), 32'd1);

        // zero-wait write
        run_cmd(1'b1, 17'h00010, 4'hF, 32'hA5A5_1234, 0, 32'h0, n_stb);
        chk("wr_stb_len", 32'(n_stb), 32'd1);
        chk("wr_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("wr_rdat", rsp_rdat, 32'd0);
        chk("wr_resp_busy", 32'(cmd_ready), 32'd0);
        chk("wr_we_drop", 32'(WBs_WE), 32'd0);
        chk("wr_adr_keep", 32'(WBs_ADR), 32'h10);
        chk("wr_dat_keep", WBs_WR_DAT, 32'hA5A5_1234);
        take_rsp();

        // read with 3 wait states
        run_cmd(1'b0, 17'h00004, 4'hF, 32'h0, 3, 32'hDEAD_BEEF, n_stb);
        chk("rd_stb_len", 32'(n_stb), 32'd4);
        chk("rd_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("rd_rdat", rsp_rdat, 32'hDEAD_BEEF);
        take_rsp();

        // timeout: no ACK ever
        run_cmd(1'b0, 17'h00008, 4'h3, 32'h0, -1, 32'h0, n_stb);
        chk("to_stb_len", 32'(n_stb), 32'd8);
        chk("to_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
        chk("to_rdat", rsp_rdat, 32'd0);
        chk("to_bus_idle", {28'd0, WBs_CYC, WBs_STB, WBs_RD, WBs_WE}, 32'd0);
        take_rsp();

        // ACK on the timeout edge wins
        run_cmd(1'b0, 17'h0000C, 4'hF, 32'h0, 7, 32'h1, n_stb);
        chk("race_stb_len", 32'(n_stb), 32'd8);
        chk("race_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("race_rdat", rsp_rdat, 32'h1);
        take_rsp();

        // response back-pressure with a pending command and a stray ACK
        run_cmd(1'b0, 17'h00014, 4'hF, 32'h0, 1, 32'hCAFE_F00D, n_stb);
        chk("bp_stb_len", 32'(n_stb), 32'd2);
        cmd_we = 1'b1; cmd_adr = 17'h00020; cmd_be = 4'hC; cmd_wdat = 32'h0BAD_F00D;
        cmd_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ok &= rsp_valid && !rsp_err && rsp_rdat == 32'hCAFE_F00D && !cmd_ready && !WBs_CYC;
            if (i == 2) begin
                WBs_ACK = 1'b1;
                WBs_RD_DAT = 32'h1234_5678;
            end
            step();
            WBs_ACK = 1'b0;
            WBs_RD_DAT = RD_BG;
        end
        chk("bp_hold", 32'(ok), 32'd1);
        chk("bp_rdat_end", rsp_rdat, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_hs_drop", 32'(rsp_valid), 32'd0);
        chk("bp_no_early", 32'(WBs_CYC), 32'd0);
        step();
        chk("bp_accept", {29'd0, WBs_STB, WBs_WE, WBs_RD}, 32'd6);
        chk("bp_adr", 32'(WBs_ADR), 32'h20);
        cmd_valid = 1'b0;
        WBs_ACK = 1'b1;
        step();
        WBs_ACK = 1'b0;
        chk("bp2_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("bp2_rdat", rsp_rdat, 32'd0);
        take_rsp();

        // async reset in the middle of a read
        cmd_we = 1'b0; cmd_adr = 17'h00018; cmd_be = 4'hF; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("mid_stb", 32'(WBs_STB), 32'd1);
        #2 WB_RST_n = 1'b0;
        #1;
        chk("arst_ctl", {28'd0, WBs_CYC, WBs_STB, WBs_RD, WBs_WE}, 32'd0);
        chk("arst_rsp", 32'(rsp_valid), 32'd0);
        @(negedge WB_CLK) WB_RST_n = 1'b1;
        step();
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        run_cmd(1'b1, 17'h0001C, 4'h1, 32'h0000_0077, 2, 32'h0, n_stb);
        chk("post_stb_len", 32'(n_stb), 32'd3);
        chk("post_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("post_rdat", rsp_rdat, 32'd0);
        take_rsp();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Hard stop in case the bench itself wedges.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
